// File: rtl/bus_txn_scheduler_if.sv
// Bundle of the per-core request, snoop broadcast and shared-memory signals of bus_txn_scheduler.
// The slave modport is the scheduler; the master modport is the cores/memory side.
interface bus_txn_scheduler_if #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_WIDTH = 64
);
  localparam int IDW = $clog2(NUM_CORES);

  logic [NUM_CORES-1:0]                 req_valid;
  logic [NUM_CORES-1:0][1:0]            req_type;
  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_CORES-1:0]                 req_ready;
  logic                                 bus_valid;
  logic [1:0]                           bus_type;
  logic [ADDR_WIDTH-1:0]                bus_addr;
  logic [IDW-1:0]                       granted_core_id;
  logic [NUM_CORES-1:0]                 snoop_resp;
  logic                                 mem_req_valid;
  logic [ADDR_WIDTH-1:0]                mem_req_addr;
  logic                                 mem_req_ready;
  logic                                 mem_resp_valid;
  logic [NUM_CORES-1:0]                 resp_valid;
  logic                                 resp_shared;
  logic                                 resp_error;
  logic                                 busy;

  modport slave (
    input  req_valid, req_type, req_addr, snoop_resp, mem_req_ready, mem_resp_valid,
    output req_ready, bus_valid, bus_type, bus_addr, granted_core_id,
           mem_req_valid, mem_req_addr, resp_valid, resp_shared, resp_error, busy
  );

  modport master (
    output req_valid, req_type, req_addr, snoop_resp, mem_req_ready, mem_resp_valid,
    input  req_ready, bus_valid, bus_type, bus_addr, granted_core_id,
           mem_req_valid, mem_req_addr, resp_valid, resp_shared, resp_error, busy
  );
endinterface

// File: rtl/bus_txn_scheduler.sv
// Single-outstanding coherency transaction sequencer: round-robin grant, snoop broadcast/collect,
// memory read, one-hot completion. Define BUS_SCHED_TIMEOUT_EN to enable the MEM_WAIT watchdog.
module bus_txn_scheduler #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int SNOOP_WAIT = 2,
  parameter int TIMEOUT    = 255
) (
  input logic              clk,
  input logic              rst,
  bus_txn_scheduler_if.slave bus_io
);
  localparam int IDW = $clog2(NUM_CORES);
  localparam int SWW = $clog2(SNOOP_WAIT + 1);
  localparam logic [SWW-1:0] SW_LAST = SWW'(SNOOP_WAIT - 1);

  if (NUM_CORES < 2 || SNOOP_WAIT < 1 || TIMEOUT < 1) begin : g_param_check
    $error("bus_txn_scheduler: NUM_CORES, SNOOP_WAIT or TIMEOUT out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_BCAST, S_SNOOP, S_MEM_REQ, S_MEM_WAIT, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [IDW-1:0]        rr_q, rr_d, id_q, id_d;
  logic [1:0]            type_q, type_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_CORES-1:0]  acc_q, acc_d;
  logic [SWW-1:0]        scnt_q, scnt_d;
  logic                  err_q, err_d;
  logic [NUM_CORES-1:0]  cand, id_oh;
  logic [IDW-1:0]        sel, idx;
  logic                  found;
  logic                  expired;

  // First eligible requester at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    sel   = rr_q;
    idx   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand[i] = bus_io.req_valid[i] & (bus_io.req_type[i] != 2'b00);
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = rr_q + IDW'(i);
      if (!found && cand[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    id_oh        = '0;
    id_oh[id_q]  = 1'b1;
  end

`ifdef BUS_SCHED_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT + 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);
  logic [TOW-1:0] tcnt_q, tcnt_d;

  // Counter only runs while in MEM_WAIT, so it is zero on every entry.
  always_comb begin
    tcnt_d = (state_q == S_MEM_WAIT) ? tcnt_q + TOW'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) tcnt_q <= '0;
    else     tcnt_q <= tcnt_d;
  end

  assign expired = (state_q == S_MEM_WAIT) && (tcnt_q == TO_LAST);
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (found) state_d = S_BCAST;
      S_BCAST:    state_d = S_SNOOP;
      S_SNOOP:    if (scnt_q == SW_LAST) state_d = (type_q == 2'b11) ? S_DONE : S_MEM_REQ;
      S_MEM_REQ:  if (bus_io.mem_req_ready) state_d = S_MEM_WAIT;
      S_MEM_WAIT: if (bus_io.mem_resp_valid || expired) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rr_d   = rr_q;
    id_d   = id_q;
    type_d = type_q;
    addr_d = addr_q;
    acc_d  = acc_q;
    scnt_d = '0;
    err_d  = err_q;
    case (state_q)
      S_IDLE: begin
        acc_d = '0;
        err_d = 1'b0;
        if (found) begin
          id_d   = sel;
          type_d = bus_io.req_type[sel];
          addr_d = bus_io.req_addr[sel];
        end
      end
      S_BCAST: begin
        rr_d  = id_q + IDW'(1);
        acc_d = acc_q | (bus_io.snoop_resp & ~id_oh);
      end
      S_SNOOP: begin
        acc_d  = acc_q | (bus_io.snoop_resp & ~id_oh);
        scnt_d = scnt_q + SWW'(1);
      end
      S_MEM_WAIT: if (!bus_io.mem_resp_valid && expired) err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q   <= '0;
      id_q   <= '0;
      acc_q  <= '0;
      scnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      id_q   <= id_d;
      acc_q  <= acc_d;
      scnt_q <= scnt_d;
      err_q  <= err_d;
    end
  end

  // Latched request payload; only observed through state-gated outputs.
  always_ff @(posedge clk) begin
    type_q <= type_d;
    addr_q <= addr_d;
  end

  always_comb begin
    bus_io.req_ready       = '0;
    bus_io.bus_valid       = 1'b0;
    bus_io.bus_type        = 2'b00;
    bus_io.bus_addr        = '0;
    bus_io.granted_core_id = id_q;
    bus_io.mem_req_valid   = 1'b0;
    bus_io.mem_req_addr    = '0;
    bus_io.resp_valid      = '0;
    bus_io.resp_shared     = 1'b0;
    bus_io.resp_error      = 1'b0;
    bus_io.busy            = (state_q != S_IDLE);
    case (state_q)
      S_BCAST: begin
        bus_io.bus_valid = 1'b1;
        bus_io.bus_type  = type_q;
        bus_io.bus_addr  = addr_q;
        bus_io.req_ready = id_oh;
      end
      S_MEM_REQ: begin
        bus_io.mem_req_valid = 1'b1;
        bus_io.mem_req_addr  = addr_q;
      end
      S_DONE: begin
        bus_io.resp_valid  = id_oh;
        bus_io.resp_shared = |acc_q;
        bus_io.resp_error  = err_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_bus_txn_scheduler.sv
// Bench for bus_txn_scheduler: directed scenarios followed by randomized transactions,
// each checked cycle by cycle against a transaction-level model of the arbitration and timing rules.
module tb_bus_txn_scheduler;
  localparam int N  = 4;
  localparam int AW = 64;
  localparam int SW = 2;
`ifdef BUS_SCHED_TIMEOUT_EN
  localparam int TO   = 8;
  localparam int LMAX = TO;
`else
  localparam int TO   = 255;
  localparam int LMAX = 6;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   rr;
  int   w;
  bit             pv[N];
  logic [1:0]     pt[N];
  logic [AW-1:0]  pa[N];

  bus_txn_scheduler_if #(.NUM_CORES(N), .ADDR_WIDTH(AW)) bif();

  bus_txn_scheduler #(
    .NUM_CORES(N), .ADDR_WIDTH(AW), .SNOOP_WAIT(SW), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_io(bif)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin reference: scan from the pointer, skipping type 00.
  function automatic int arb();
    for (int i = 0; i < N; i++) begin
      int c;
      c = (rr + i) % N;
      if (pv[c] && pt[c] != 2'b00) return c;
    end
    return -1;
  endfunction

  task automatic drive_reqs();
    for (int c = 0; c < N; c++) begin
      bif.req_valid[c] = pv[c];
      bif.req_type[c]  = pt[c];
      bif.req_addr[c]  = pa[c];
    end
  endtask

  task automatic setup_one(input int c, input logic [1:0] t, input logic [AW-1:0] a);
    for (int k = 0; k < N; k++) pv[k] = 1'b0;
    pv[c] = 1'b1;
    pt[c] = t;
    pa[c] = a;
    drive_reqs();
  endtask

  task automatic refill();
    int c;
    for (int k = 0; k < N; k++) begin
      if ((!pv[k] || pt[k] == 2'b00) && $urandom_range(0, 1) == 1) begin
        pv[k] = 1'b1;
        pt[k] = 2'($urandom_range(0, 3));
        pa[k] = {$urandom, $urandom};
      end
    end
    if (arb() < 0) begin
      c = $urandom_range(0, N - 1);
      pv[c] = 1'b1;
      pt[c] = 2'($urandom_range(1, 3));
      pa[c] = {$urandom, $urandom};
    end
    drive_reqs();
  endtask

  task automatic chk_quiet(input string ph, input logic exp_busy);
    chk_eq({ph, "/bus_valid"},     64'(bif.bus_valid),     64'(0));
    chk_eq({ph, "/req_ready"},     64'(bif.req_ready),     64'(0));
    chk_eq({ph, "/mem_req_valid"}, 64'(bif.mem_req_valid), 64'(0));
    chk_eq({ph, "/resp_valid"},    64'(bif.resp_valid),    64'(0));
    chk_eq({ph, "/busy"},          64'(bif.busy),          64'(exp_busy));
  endtask

  task automatic chk_zero_all(input string ph);
    chk_quiet(ph, 1'b0);
    chk_eq({ph, "/granted"},      64'(bif.granted_core_id), 64'(0));
    chk_eq({ph, "/bus_type"},     64'(bif.bus_type),        64'(0));
    chk_eq({ph, "/bus_addr"},     64'(bif.bus_addr),        64'(0));
    chk_eq({ph, "/mem_req_addr"}, 64'(bif.mem_req_addr),    64'(0));
    chk_eq({ph, "/resp_shared"},  64'(bif.resp_shared),     64'(0));
    chk_eq({ph, "/resp_error"},   64'(bif.resp_error),      64'(0));
  endtask

  task automatic idle_step(input int last);
    tick();
    chk_quiet("idle", 1'b0);
    chk_eq("idle/granted_hold", 64'(bif.granted_core_id), 64'(last));
  endtask

  // Entered during an IDLE cycle with requests driven; returns during the DONE cycle
  // (or during an IDLE cycle after an injected reset).
  task automatic run_txn(input int acc_dly, input int mem_lat, input bit frc,
                         input logic [N-1:0] fsnp, input bit rst_in_wait, output int win);
    logic [N-1:0]  oh, s, acc;
    logic [1:0]    t;
    logic [AW-1:0] a;
    bit            exp_err;
    win = arb();
    chk_eq("arb_eligible", 64'(win >= 0), 64'(1));
    if (win < 0) return;
    t = pt[win];
    a = pa[win];
    oh = '0;
    oh[win] = 1'b1;
    acc = '0;
    exp_err = 1'b0;
    bif.mem_req_ready  = 1'b0;
    bif.mem_resp_valid = 1'b0;

    tick();
    chk_eq("bcast/bus_valid", 64'(bif.bus_valid),       64'(1));
    chk_eq("bcast/granted",   64'(bif.granted_core_id), 64'(win));
    chk_eq("bcast/bus_type",  64'(bif.bus_type),        64'(t));
    chk_eq("bcast/bus_addr",  64'(bif.bus_addr),        64'(a));
    chk_eq("bcast/req_ready", 64'(bif.req_ready),       64'(oh));
    chk_eq("bcast/busy",      64'(bif.busy),            64'(1));
    chk_eq("bcast/mem_req",   64'(bif.mem_req_valid),   64'(0));
    chk_eq("bcast/resp",      64'(bif.resp_valid),      64'(0));
    pv[win] = 1'b0;
    rr = (win + 1) % N;
    drive_reqs();
    s = frc ? fsnp : N'($urandom);
    acc |= s & ~oh;
    bif.snoop_resp = s;
    bif.mem_resp_valid = 1'($urandom_range(0, 1));

    for (int j = 0; j < SW; j++) begin
      tick();
      chk_quiet("snoop", 1'b1);
      chk_eq("snoop/granted", 64'(bif.granted_core_id), 64'(win));
      s = frc ? fsnp : N'($urandom);
      acc |= s & ~oh;
      bif.snoop_resp = s;
      bif.mem_resp_valid = 1'($urandom_range(0, 1));
    end

    tick();
    bif.mem_resp_valid = 1'b0;
    bif.snoop_resp = N'($urandom);
    if (t != 2'b11) begin
      for (int k = 0; k <= acc_dly; k++) begin
        if (k > 0) tick();
        chk_eq("memreq/valid", 64'(bif.mem_req_valid), 64'(1));
        chk_eq("memreq/addr",  64'(bif.mem_req_addr),  64'(a));
        chk_eq("memreq/bus",   64'(bif.bus_valid),     64'(0));
        chk_eq("memreq/resp",  64'(bif.resp_valid),    64'(0));
        bif.mem_req_ready  = (k == acc_dly);
        bif.mem_resp_valid = (k < acc_dly) ? 1'($urandom_range(0, 1)) : 1'b0;
        bif.snoop_resp     = N'($urandom);
      end
      tick();
      bif.mem_req_ready = 1'b0;
      if (rst_in_wait) begin
        rst = 1'b1;
        for (int k = 0; k < N; k++) pv[k] = 1'b0;
        drive_reqs();
        tick();
        rst = 1'b0;
        rr  = 0;
        bif.mem_resp_valid = 1'b1;
        chk_zero_all("after_rst");
        tick();
        bif.mem_resp_valid = 1'b0;
        chk_quiet("after_rst_idle", 1'b0);
        return;
      end
      for (int cyc = 1; cyc <= TO + 4; cyc++) begin
        chk_quiet("memwait", 1'b1);
        if (mem_lat != 0 && cyc == mem_lat) begin
          bif.mem_resp_valid = 1'b1;
          tick();
          bif.mem_resp_valid = 1'b0;
          break;
        end
`ifdef BUS_SCHED_TIMEOUT_EN
        if (cyc == TO) begin
          exp_err = 1'b1;
          tick();
          break;
        end
`endif
        tick();
      end
    end

    chk_eq("done/resp_valid",  64'(bif.resp_valid),    64'(oh));
    chk_eq("done/resp_shared", 64'(bif.resp_shared),   64'(|acc));
    chk_eq("done/resp_error",  64'(bif.resp_error),    64'(exp_err));
    chk_eq("done/bus_valid",   64'(bif.bus_valid),     64'(0));
    chk_eq("done/mem_req",     64'(bif.mem_req_valid), 64'(0));
    chk_eq("done/req_ready",   64'(bif.req_ready),     64'(0));
    chk_eq("done/busy",        64'(bif.busy),          64'(1));
    bif.snoop_resp = '0;
  endtask

  initial begin
    rst = 1'b1;
    rr  = 0;
    w   = 0;
    bif.snoop_resp     = '0;
    bif.mem_req_ready  = 1'b0;
    bif.mem_resp_valid = 1'b0;
    for (int c = 0; c < N; c++) begin
      pv[c] = 1'b1;
      pt[c] = 2'b01;
      pa[c] = AW'(32'h1000 + c * 64);
    end
    drive_reqs();

    repeat (3) begin
      tick();
      chk_zero_all("reset");
    end
    rst = 1'b0;
    chk_zero_all("rst_release");

    for (int i = 0; i < 5; i++) begin
      run_txn(0, 4, 1'b0, '0, 1'b0, w);
      chk_eq("rr_order", 64'(w), 64'(i % N));
      if (i < 4) begin
        pv[w] = 1'b1;
        drive_reqs();
      end else begin
        setup_one(2, 2'b11, 64'h1000);
      end
      idle_step(w);
    end

    run_txn(0, 0, 1'b1, 4'b0010, 1'b0, w);
    chk_eq("upgr_core", 64'(w), 64'(2));
    setup_one(3, 2'b01, 64'hABCD_0000_1234_5678);
    idle_step(w);

    run_txn(5, 3, 1'b1, 4'b1000, 1'b0, w);
    chk_eq("selfsnoop_core", 64'(w), 64'(3));
    setup_one(1, 2'b01, 64'h40);
    idle_step(w);

    run_txn(0, 3, 1'b0, '0, 1'b1, w);
    pv[0] = 1'b1; pt[0] = 2'b01; pa[0] = 64'h80;
    pv[2] = 1'b1; pt[2] = 2'b10; pa[2] = 64'hC0;
    drive_reqs();
    run_txn(1, 2, 1'b0, '0, 1'b0, w);
    chk_eq("post_rst_grant", 64'(w), 64'(0));

`ifdef BUS_SCHED_TIMEOUT_EN
    setup_one(1, 2'b10, 64'h77);
    idle_step(w);
    run_txn(0, 0, 1'b0, '0, 1'b0, w);
    for (int k = 0; k < N; k++) pv[k] = 1'b0;
    drive_reqs();
    bif.mem_resp_valid = 1'b1;
    idle_step(w);
    tick();
    bif.mem_resp_valid = 1'b0;
    chk_quiet("late_resp", 1'b0);
    refill();
`else
    refill();
    idle_step(w);
`endif

    for (int n = 0; n < 200; n++) begin
      run_txn($urandom_range(0, 3), $urandom_range(1, LMAX), 1'b0, '0, 1'b0, w);
      refill();
      idle_step(w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
